lru_sched: RTL

LRU_SCHED -- requirements
Module: lru_sched

---
 rtl/lru_sched_pkg.sv | 26 ++
 rtl/lru_hit_fifo.sv | 71 +++++++
 rtl/lru_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lru_sched_pkg.sv
// Shared definitions for the LRU update scheduler.
//   - state_e     : scheduler FSM states
//   - *Default    : default set-index width and way count
//   - lowest_bit  : isolates the lowest set bit of a way vector (one-hot select)
package lru_sched_pkg;

  localparam int unsigned SetWDefault = 7;
  localparam int unsigned WaysDefault = 8;
  // Widest way vector lowest_bit() can handle; callers cast in and out.
  localparam int unsigned MaxWays     = 64;

  typedef enum logic [2:0] {
    StIdle,
    StHitUpd,
    StVicRd,
    StVicCap,
    StFillWait,
    StFillUpd
  } state_e;

  // Two's-complement trick: v & -v keeps only the lowest set bit; zero stays zero.
  function automatic logic [MaxWays-1:0] lowest_bit(input logic [MaxWays-1:0] v);
    return v & (~v + MaxWays'(1));
  endfunction

endpackage

// File: rtl/lru_hit_fifo.sv
// Synchronous hit-update queue.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i : write an entry (ignored when full unless a pop happens together)
//   pop_i/rdata_o  : pop the head; rdata_o always shows the current head
//   full_o/empty_o/count_o : occupancy
// Depth must be a power of two so the pointers wrap naturally.
module lru_hit_fifo #(
  parameter int unsigned Width = 15,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full queue is fine when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/lru_sched.sv
// Scheduler in front of an LRU buffer: queues hit updates, serves victim
// queries for misses, and issues the post-refill LRU update.
//   clk, rst (async, active-low)
//   i_hit_*  / o_hit_ready  : hit-update request channel (valid/ready)
//   i_miss_* / o_miss_ready : victim-query channel (valid/ready, IDLE only)
//   o_victim_valid/o_victim_way_8 : one-cycle victim pulse per accepted miss
//   i_fill_done    : refill of the returned victim finished
//   o_lru_*        : drive the LRU buffer; i_lru_flag_8 is its flag output
//   o_busy         : FSM not idle or hits still queued
// All outputs are registered except the two ready signals.
module lru_sched
  import lru_sched_pkg::*;
#(
  parameter int unsigned SET_W      = SetWDefault,
  parameter int unsigned WAYS       = WaysDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hit_valid,
  output logic             o_hit_ready,
  input  logic [SET_W-1:0] i_hit_addr_7,
  input  logic [WAYS-1:0]  i_hit_way_8,
  input  logic             i_miss_valid,
  output logic             o_miss_ready,
  input  logic [SET_W-1:0] i_miss_addr_7,
  output logic             o_victim_valid,
  output logic [WAYS-1:0]  o_victim_way_8,
  input  logic             i_fill_done,
  output logic [SET_W-1:0] o_lru_addr_7,
  output logic [WAYS-1:0]  o_lru_hit_way_8,
  output logic             o_lru_hit_sig,
  input  logic [WAYS-1:0]  i_lru_flag_8,
  output logic             o_busy
);

  localparam int unsigned EntryW = SET_W + WAYS;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [SET_W-1:0] miss_addr_q, miss_addr_d;
  logic             victim_valid_q, victim_valid_d;
  logic [WAYS-1:0]  victim_way_q, victim_way_d;
  logic [SET_W-1:0] lru_addr_q, lru_addr_d;
  logic [WAYS-1:0]  lru_way_q, lru_way_d;
  logic             lru_sig_q, lru_sig_d;
  logic             busy_q, busy_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_rdata;
  logic [CntW-1:0]   fifo_count, fifo_count_next;
  logic [SET_W-1:0]  head_addr;
  logic [WAYS-1:0]   head_way;
  logic              miss_xfer;

  assign o_hit_ready  = ~fifo_full;
  // Gated by rst so no miss is offered while held in reset.
  assign o_miss_ready = rst & (state_q == StIdle) & ~fifo_full;
  assign miss_xfer    = i_miss_valid & o_miss_ready;
  // All-zero way vectors carry no update and are dropped at the door.
  assign fifo_push    = i_hit_valid & o_hit_ready & (|i_hit_way_8);

  assign head_addr = fifo_rdata[EntryW-1:WAYS];
  assign head_way  = fifo_rdata[WAYS-1:0];

  lru_hit_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .wdata_i ({i_hit_addr_7, i_hit_way_8}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign fifo_count_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);

  always_comb begin
    state_d        = state_q;
    miss_addr_d    = miss_addr_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    lru_addr_d     = lru_addr_q;
    lru_way_d      = '0;
    lru_sig_d      = 1'b0;
    fifo_pop       = 1'b0;

    case (state_q)
      StIdle: begin
        // A full queue blocks miss_ready, so miss_xfer already loses to it.
        if (miss_xfer) begin
          state_d     = StVicRd;
          miss_addr_d = i_miss_addr_7;
          lru_addr_d  = i_miss_addr_7;
        end else if (!fifo_empty) begin
          // Outputs are registered, so the head is popped and latched on entry.
          state_d    = StHitUpd;
          fifo_pop   = 1'b1;
          lru_sig_d  = 1'b1;
          lru_addr_d = head_addr;
          lru_way_d  = WAYS'(lowest_bit(MaxWays'(head_way)));
        end
      end
      StHitUpd: state_d = StIdle;
      // Address stays on the buffer input so its flag is valid in StVicCap.
      StVicRd:  state_d = StVicCap;
      StVicCap: begin
        state_d        = StFillWait;
        victim_valid_d = 1'b1;
        victim_way_d   = (i_lru_flag_8 == '0) ? WAYS'(1)
                                              : WAYS'(lowest_bit(MaxWays'(i_lru_flag_8)));
      end
      StFillWait: begin
        if (i_fill_done) begin
          state_d    = StFillUpd;
          lru_sig_d  = 1'b1;
          lru_addr_d = miss_addr_q;
          lru_way_d  = victim_way_q;
        end
      end
      StFillUpd: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) | (fifo_count_next != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      miss_addr_q    <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      lru_addr_q     <= '0;
      lru_way_q      <= '0;
      lru_sig_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      miss_addr_q    <= miss_addr_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      lru_addr_q     <= lru_addr_d;
      lru_way_q      <= lru_way_d;
      lru_sig_q      <= lru_sig_d;
      busy_q         <= busy_d;
    end
  end

  assign o_victim_valid  = victim_valid_q;
  assign o_victim_way_8  = victim_way_q;
  assign o_lru_addr_7    = lru_addr_q;
  assign o_lru_hit_way_8 = lru_way_q;
  assign o_lru_hit_sig   = lru_sig_q;
  assign o_busy          = busy_q;

endmodule
